// File: rtl/rv_decode_pkg.sv
// Shared opcodes, instruction classes and the decoded-bundle layout for the decode stage.
// Immediates are carried at full 64-bit width and narrowed to XLEN at the stage output.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int IMM_W = 64;

    typedef enum logic [3:0] {
        R_COMP  = 4'd0,
        I_COMP  = 4'd1,
        I_MEM   = 4'd2,
        I_JUMP  = 4'd3,
        S_MEM   = 4'd4,
        B_JUMP  = 4'd5,
        U_LUI   = 4'd6,
        J_JUMP  = 4'd7,
        U_AUIPC = 4'd8,
        FENCE   = 4'd9,
        SYSTEM  = 4'd10,
        ILLEGAL = 4'd15
    } rv_class_e;

    typedef struct packed {
        rv_class_e        cls;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rs1_used;
        logic             rs2_used;
        logic             rd_we;
        logic [IMM_W-1:0] imm;
        logic             word;
        logic             illegal;
    } dec_bundle_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I/RV64I word-to-bundle decoder with illegal-instruction detection.
// No state, no handshake: pure function of the instruction word and XLEN.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rs1_f, rs2_f, rd_f;
    logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign rd_f   = instr[11:7];

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    rv_class_e        cls;
    logic             use_rs1, use_rs2, use_rd, word, bad;
    logic [IMM_W-1:0] imm;

    always_comb begin
        cls     = R_COMP;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm     = '0;
        word    = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                cls     = R_COMP;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                word    = (opcode == OPC_OP_32);
                bad     = (f7 != 7'h00 && f7 != 7'h20) ||
                          (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) ||
                          (opcode == OPC_OP_32 && !RV64);
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                cls     = I_COMP;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
                word    = (opcode == OPC_OP_IMM_32);
                // shift-immediates reuse the upper immediate bits as a funct7-like qualifier
                if (f3 == 3'b001)
                    bad = (f7[6:1] != 6'b000000);
                else if (f3 == 3'b101)
                    bad = (f7[6:1] != 6'b000000) && (f7[6:1] != 6'b010000);
                if ((f3 == 3'b001 || f3 == 3'b101) && !RV64 && instr[25])
                    bad = 1'b1;
                if (opcode == OPC_OP_IMM_32 && !RV64)
                    bad = 1'b1;
            end
            OPC_LOAD: begin
                cls     = I_MEM;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
                bad     = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_JALR: begin
                cls     = I_JUMP;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
                bad     = (f3 != 3'b000);
            end
            OPC_STORE: begin
                cls     = S_MEM;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_s;
                bad     = RV64 ? (f3 > 3'd3) : (f3 > 3'd2);
            end
            OPC_BRANCH: begin
                cls     = B_JUMP;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_b;
                bad     = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LUI: begin
                cls    = U_LUI;
                use_rd = 1'b1;
                imm    = imm_u;
            end
            OPC_AUIPC: begin
                cls    = U_AUIPC;
                use_rd = 1'b1;
                imm    = imm_u;
            end
            OPC_JAL: begin
                cls    = J_JUMP;
                use_rd = 1'b1;
                imm    = imm_j;
            end
            OPC_MISC_MEM: begin
                cls = FENCE;
                imm = imm_i;
            end
            OPC_SYSTEM: begin
                cls     = SYSTEM;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = imm_i;
            end
            default: bad = 1'b1;
        endcase

        bundle        = '0;
        bundle.funct3 = f3;
        bundle.funct7 = f7;
        if (bad) begin
            bundle.cls     = ILLEGAL;
            bundle.illegal = 1'b1;
        end else begin
            bundle.cls      = cls;
            bundle.rs1      = use_rs1 ? rs1_f : 5'd0;
            bundle.rs2      = use_rs2 ? rs2_f : 5'd0;
            bundle.rd       = use_rd ? rd_f : 5'd0;
            bundle.rs1_used = use_rs1;
            bundle.rs2_used = use_rs2;
            bundle.rd_we    = use_rd && (rd_f != 5'd0);
            bundle.imm      = imm;
            bundle.word     = word;
        end
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: one-cycle latency, full throughput, 2-entry skid so in_ready is a flop.
// A stalled output holds its fields; a second word parks in the skid slot and in_ready drops.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output rv_class_e       out_class,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic            out_word,
    output logic            out_illegal
);

    dec_bundle_t     dec, out_q, skid_q;
    logic [PC_W-1:0] out_pc_q, skid_pc_q;
    logic            out_valid_q, skid_valid_q;
    logic            in_fire;
    logic            unused_imm;

    rv_decode_comb #(.XLEN(XLEN)) u_comb (
        .instr  (in_instr),
        .bundle (dec)
    );

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // output slot frees up this cycle: the older skid entry always goes first
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_pc_q     <= skid_pc_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_q    <= dec;
                    out_pc_q <= in_pc;
                end
            end
        end else if (in_fire) begin
            skid_q       <= dec;
            skid_pc_q    <= in_pc;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_class    = out_q.cls;
    assign out_funct3   = out_q.funct3;
    assign out_funct7   = out_q.funct7;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_rd       = out_q.rd;
    assign out_rs1_used = out_q.rs1_used;
    assign out_rs2_used = out_q.rs2_used;
    assign out_rd_we    = out_q.rd_we;
    assign out_imm      = out_q.imm[XLEN-1:0];
    assign out_word     = out_q.word;
    assign out_illegal  = out_q.illegal;

    // upper immediate bits are only consumed when XLEN=64
    assign unused_imm = ^out_q.imm;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Randomized and directed bench for rv_decode_stage, XLEN=32 and XLEN=64 instances in lockstep.
module tb_rv_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        r32, v32, u1_32, u2_32, we32, w32, ill32;
    logic [31:0] pc32, imm32;
    logic [3:0]  cls32;
    logic [2:0]  f3_32;
    logic [6:0]  f7_32;
    logic [4:0]  rs1_32, rs2_32, rd32;

    logic        r64, v64, u1_64, u2_64, we64, w64, ill64;
    logic [31:0] pc64;
    logic [63:0] imm64;
    logic [3:0]  cls64;
    logic [2:0]  f3_64;
    logic [6:0]  f7_64;
    logic [4:0]  rs1_64, rs2_64, rd64;

    rv_decode_stage #(.XLEN(32), .PC_W(32)) u32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v32), .out_ready(out_ready), .out_pc(pc32), .out_class(cls32),
        .out_funct3(f3_32), .out_funct7(f7_32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_rd(rd32), .out_rs1_used(u1_32), .out_rs2_used(u2_32), .out_rd_we(we32),
        .out_imm(imm32), .out_word(w32), .out_illegal(ill32)
    );

    rv_decode_stage #(.XLEN(64), .PC_W(32)) u64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_pc(pc64), .out_class(cls64),
        .out_funct3(f3_64), .out_funct7(f7_64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_rd(rd64), .out_rs1_used(u1_64), .out_rs2_used(u2_64), .out_rd_we(we64),
        .out_imm(imm64), .out_word(w64), .out_illegal(ill64)
    );

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rs1, rs2, rd;
        logic        r1u, r2u, we;
        logic [63:0] imm;
        logic        word, ill;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decoder: picks an instruction format, then derives fields from the format.
    function automatic exp_t ref_decode(input logic [31:0] w, input int xlen);
        exp_t       e;
        byte        fmt;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         bad, rv64;
        longint     sw;
        e    = '0;
        f3   = w[14:12];
        f7   = w[31:25];
        rv64 = (xlen == 64);
        sw   = longint'($signed(w));
        bad  = 1'b0;
        fmt  = "X";
        case (w[6:0])
            7'h33: begin e.cls = 0; fmt = "R"; end
            7'h3B: begin e.cls = 0; fmt = "R"; e.word = 1; bad = !rv64; end
            7'h13: begin e.cls = 1; fmt = "I"; end
            7'h1B: begin e.cls = 1; fmt = "I"; e.word = 1; bad = !rv64; end
            7'h03: begin e.cls = 2; fmt = "I"; bad = (f3 == 7) || (!rv64 && (f3 == 3 || f3 == 6)); end
            7'h67: begin e.cls = 3; fmt = "I"; bad = (f3 != 0); end
            7'h23: begin e.cls = 4; fmt = "S"; bad = rv64 ? (f3 > 3) : (f3 > 2); end
            7'h63: begin e.cls = 5; fmt = "B"; bad = (f3 == 2) || (f3 == 3); end
            7'h37: begin e.cls = 6; fmt = "U"; end
            7'h17: begin e.cls = 8; fmt = "U"; end
            7'h6F: begin e.cls = 7; fmt = "J"; end
            7'h0F: begin e.cls = 9; fmt = "F"; end
            7'h73: begin e.cls = 10; fmt = "I"; end
            default: bad = 1'b1;
        endcase
        if (fmt == "R" && !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))))
            bad = 1'b1;
        if ((w[6:0] == 7'h13 || w[6:0] == 7'h1B) && (f3 == 1 || f3 == 5)) begin
            if (f3 == 1 && w[31:26] != 0) bad = 1'b1;
            if (f3 == 5 && w[31:26] != 0 && w[31:26] != 6'h10) bad = 1'b1;
            if (!rv64 && w[25]) bad = 1'b1;
        end
        if (bad) begin
            e     = '0;
            e.cls = 15;
            e.ill = 1'b1;
            return e;
        end
        case (fmt)
            "I", "F": e.imm = sw >>> 20;
            "S": e.imm = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
            "B": e.imm = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                         (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            "U": e.imm = sw & ~longint'(12'hFFF);
            "J": e.imm = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                         (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            default: e.imm = 0;
        endcase
        e.r1u = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
        e.r2u = (fmt == "R" || fmt == "S" || fmt == "B");
        if (e.r1u) e.rs1 = w[19:15];
        if (e.r2u) e.rs2 = w[24:20];
        if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") e.rd = w[11:7];
        e.we = (e.rd != 0);
        if (xlen == 32) e.imm = {32'b0, e.imm[31:0]};
        return e;
    endfunction

    task automatic cmp_bundle(input string p, input int xlen, input ent_t en,
                              input logic [31:0] pc, input logic [3:0] cls,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic u1, input logic u2, input logic we,
                              input logic [63:0] imm, input logic wd, input logic ill);
        exp_t x;
        x = ref_decode(en.w, xlen);
        check({p, ".pc"}, pc, en.pc);
        check({p, ".class"}, cls, x.cls);
        check({p, ".funct3"}, f3, en.w[14:12]);
        check({p, ".funct7"}, f7, en.w[31:25]);
        check({p, ".rs1"}, rs1, x.rs1);
        check({p, ".rs2"}, rs2, x.rs2);
        check({p, ".rd"}, rd, x.rd);
        check({p, ".rs1_used"}, u1, x.r1u);
        check({p, ".rs2_used"}, u2, x.r2u);
        check({p, ".rd_we"}, we, x.we);
        check({p, ".imm"}, imm, x.imm);
        check({p, ".word"}, wd, x.word);
        check({p, ".illegal"}, ill, x.ill);
    endtask

    // Scoreboard: q holds accepted, not-yet-delivered words; its depth defines valid/ready.
    always @(negedge clk) begin
        if (mon_en) begin
            bit can_in, can_out;
            can_in  = (q.size() < 2);
            can_out = (q.size() > 0);
            check("in_ready32", r32, can_in);
            check("in_ready64", r64, can_in);
            check("out_valid32", v32, can_out);
            check("out_valid64", v64, can_out);
            if (can_out && v32)
                cmp_bundle("d32", 32, q[0], pc32, cls32, f3_32, f7_32, rs1_32, rs2_32, rd32,
                           u1_32, u2_32, we32, {32'b0, imm32}, w32, ill32);
            if (can_out && v64)
                cmp_bundle("d64", 64, q[0], pc64, cls64, f3_64, f7_64, rs1_64, rs2_64, rd64,
                           u1_64, u2_64, we64, imm64, w64, ill64);
            if (can_out && out_ready) void'(q.pop_front());
            if (can_in && in_valid) q.push_back('{in_instr, in_pc});
            if (flush || reset) q.delete();
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc_ctr;
        out_ready = ordy;
        flush     = fl;
        pc_ctr    = pc_ctr + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        check({p, ".in_ready"}, {r32, r64}, 2'b11);
        check({p, ".valid"}, {v32, v64}, 2'b00);
        check({p, ".pc"}, {pc32, pc64}, 64'd0);
        check({p, ".cls_f3_f7"}, {cls32, f3_32, f7_32, cls64, f3_64, f7_64}, 64'd0);
        check({p, ".regs"}, {rs1_32, rs2_32, rd32, rs1_64, rs2_64, rd64}, 64'd0);
        check({p, ".flags"}, {u1_32, u2_32, we32, w32, ill32, u1_64, u2_64, we64, w64, ill64}, 64'd0);
        check({p, ".imm32"}, imm32, 64'd0);
        check({p, ".imm64"}, imm64, 64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 12))
                0: w[6:0] = 7'h33;  1: w[6:0] = 7'h3B;  2: w[6:0] = 7'h13;
                3: w[6:0] = 7'h1B;  4: w[6:0] = 7'h03;  5: w[6:0] = 7'h67;
                6: w[6:0] = 7'h23;  7: w[6:0] = 7'h63;  8: w[6:0] = 7'h37;
                9: w[6:0] = 7'h17;  10: w[6:0] = 7'h6F; 11: w[6:0] = 7'h0F;
                default: w[6:0] = 7'h73;
            endcase
        end
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:26] = 6'h00;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // back-to-back directed words with out_ready=1: each one is on the output one edge later
        drive(1, 32'h00500093, 1, 0);
        check("addi.class", cls32, 4'd1);
        check("addi.rd", rd32, 5'd1);
        check("addi.rs1", rs1_32, 5'd0);
        check("addi.imm", imm32, 32'd5);
        check("addi.rd_we", we32, 1'b1);
        check("addi.in_ready", r32, 1'b1);
        drive(1, 32'hFE000EE3, 1, 0);
        check("beq.class", cls32, 4'd5);
        check("beq.imm32", imm32, 32'hFFFF_FFFC);
        check("beq.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq.we_used", {we32, u1_32, u2_32}, 3'b011);
        drive(1, 32'h12345297, 1, 0);
        check("auipc.class", cls32, 4'd8);
        check("auipc.rd", rd32, 5'd5);
        check("auipc.imm", imm32, 32'h1234_5000);
        drive(1, 32'h00000000, 1, 0);
        check("zero.illegal", {v32, ill32, cls32}, {2'b11, 4'hF});
        drive(1, 32'h40001033, 1, 0);
        check("sll_bad.illegal", {v32, ill32, we32}, 3'b110);
        drive(1, 32'h0000B083, 1, 0);
        check("ld32.illegal", {v32, ill32, imm32}, {2'b11, 32'd0});
        check("ld64.class", {ill64, cls64}, {1'b0, 4'd2});
        drive(1, 32'hFFF00093, 1, 0);
        check("addi64.imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 32'h0010009B, 1, 0);
        check("addiw64", {w64, cls64, ill64}, {1'b1, 4'd1, 1'b0});
        check("addiw32.illegal", {w32, ill32}, 2'b01);
        drive(0, 32'h0, 1, 0);

        // stall: two accepted, third refused, then drain in order
        drive(1, 32'h00100113, 0, 0);
        drive(1, 32'h00200193, 0, 0);
        check("stall.in_ready", r32, 1'b0);
        drive(1, 32'h00300213, 0, 0);
        drive(1, 32'h00300213, 0, 0);
        repeat (4) drive(0, 32'h0, 1, 0);

        // flush with both slots full and in_valid high, then flush of an accepted word
        drive(1, 32'h00400293, 0, 0);
        drive(1, 32'h00500313, 0, 0);
        drive(1, 32'h00600393, 0, 1);
        check("flush_full.state", {v32, r32, v64, r64}, 4'b0101);
        drive(1, 32'h00700413, 0, 0);
        drive(1, 32'h00800493, 0, 1);
        check("flush_hs.state", {v32, r32}, 2'b01);
        drive(1, 32'h00900513, 1, 0);
        drive(0, 32'h0, 1, 0);

        // reset while stalled
        drive(1, 32'h00A00593, 0, 0);
        drive(1, 32'h00B00613, 0, 0);
        reset = 1'b1;
        drive(0, 32'h0, 0, 0);
        check_zero("reset_stall");
        reset = 1'b0;

        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
        repeat (4) drive(0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
